// File: rtl/sram_pkg.sv
// Shared types and helpers for the bit-masked 1RW memory model.
// Also defines the elaboration check used by the top level.
package sram_pkg;

  typedef enum logic {INIT, RUN} sram_state_e;

  localparam int unsigned SRAM_MAX_W = 256;

  // Widen a lane mask into a per-bit write enable; callers truncate to WIDTH.
  function automatic logic [SRAM_MAX_W-1:0] lane_expand(input logic [SRAM_MAX_W-1:0] mask,
                                                         input int unsigned gran);
    logic [SRAM_MAX_W-1:0] en;
    en = '0;
    for (int unsigned i = 0; i < SRAM_MAX_W; i++) begin
      en[i] = mask[i / gran];
    end
    return en;
  endfunction

endpackage

`define SRAM_CHECK_GRAN(W, G) \
  if ((G) == 0 || ((W) % (G)) != 0) begin : g_bad_mask_gran \
    $error("sram: WIDTH must be a multiple of MASK_GRAN"); \
  end

// File: rtl/sram_init_seq.sv
// Post-reset initialiser: walks every address once, then raises ready.
// ready is registered and depends only on FSM state.
module sram_init_seq
  import sram_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              init_we_o,
  output logic [ADDR_W-1:0] init_addr_o,
  output logic              ready_o
);

  sram_state_e       state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              ready_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        RUN: ready_q <= 1'b1;
        default: begin
          state_q <= INIT;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign init_we_o   = (state_q == INIT) && !rst_i;
  assign init_addr_o = cnt_q;
  assign ready_o     = ready_q;

endmodule

// File: rtl/sram_1rw_mask_ext.sv
// Single-port bit-masked synchronous memory with init-on-reset,
// held registered read data and a one-cycle read-valid strobe.
module sram_1rw_mask_ext
  import sram_pkg::*;
#(
  parameter int unsigned      DEPTH     = 32,
  parameter int unsigned      WIDTH     = 4,
  parameter int unsigned      MASK_GRAN = 1,
  parameter logic [WIDTH-1:0] INIT_VAL  = '0,
  parameter int unsigned      ADDR_W    = $clog2(DEPTH),
  parameter int unsigned      MASK_W    = WIDTH / MASK_GRAN
) (
  input  logic              RW0_clk,
  input  logic              RW0_reset,
  input  logic              RW0_en,
  input  logic              RW0_wmode,
  input  logic [ADDR_W-1:0] RW0_addr,
  input  logic [MASK_W-1:0] RW0_wmask,
  input  logic [WIDTH-1:0]  RW0_wdata,
  output logic [WIDTH-1:0]  RW0_rdata,
  output logic              RW0_rvalid,
  output logic              RW0_ready
);

  `SRAM_CHECK_GRAN(WIDTH, MASK_GRAN)

  if (WIDTH > SRAM_MAX_W) begin : g_too_wide
    $error("sram: WIDTH exceeds SRAM_MAX_W");
  end

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic              ready;

  sram_init_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .clk_i       (RW0_clk),
    .rst_i       (RW0_reset),
    .init_we_o   (init_we),
    .init_addr_o (init_addr),
    .ready_o     (ready)
  );

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              in_range;
  logic              user_wr;
  logic              user_rd;
  logic [WIDTH-1:0]  user_ben;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_ben;
  logic [WIDTH-1:0]  rdata_d;
  logic [WIDTH-1:0]  rdata_q;
  logic              rvalid_q;

  assign in_range = 32'(RW0_addr) < DEPTH;
  assign user_wr  = ready && RW0_en && RW0_wmode && in_range;
  assign user_rd  = ready && RW0_en && !RW0_wmode;
  assign user_ben = WIDTH'(lane_expand(SRAM_MAX_W'(RW0_wmask), MASK_GRAN));

  // Init and user writes never overlap: ready is low for the whole INIT state.
  always_comb begin
    mem_we    = init_we || user_wr;
    mem_addr  = RW0_addr;
    mem_wdata = RW0_wdata;
    mem_ben   = user_ben;
    if (init_we) begin
      mem_addr  = init_addr;
      mem_wdata = INIT_VAL;
      mem_ben   = '1;
    end
  end

  always_ff @(posedge RW0_clk) begin
    if (mem_we) begin
      mem[mem_addr] <= (mem[mem_addr] & ~mem_ben) | (mem_wdata & mem_ben);
    end
  end

  always_comb begin
    rdata_d = '0;
    if (in_range) begin
      rdata_d = mem[RW0_addr];
    end
  end

  always_ff @(posedge RW0_clk) begin
    if (RW0_reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= user_rd;
      if (user_rd) begin
        rdata_q <= rdata_d;
      end
    end
  end

  assign RW0_rdata  = rdata_q;
  assign RW0_rvalid = rvalid_q;
  assign RW0_ready  = ready;

endmodule

// File: tb/tb_sram_1rw_mask_ext.sv
// Self-checking bench: reference array model with a read scoreboard,
// a directed vector table, init/reset sequences and a random run.
module tb_sram_1rw_mask_ext;

  localparam int unsigned DEPTH = 20;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned GRAN  = 4;
  localparam int unsigned MW    = WIDTH / GRAN;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] IV = 8'hA5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             wmode = 1'b0;
  logic [AW-1:0]    addr = '0;
  logic [MW-1:0]    wmask = '0;
  logic [WIDTH-1:0] wdata = '0;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             ready;

  always #5 clk = ~clk;

  sram_1rw_mask_ext #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .MASK_GRAN (GRAN),
    .INIT_VAL  (IV)
  ) dut (
    .RW0_clk    (clk),
    .RW0_reset  (rst),
    .RW0_en     (en),
    .RW0_wmode  (wmode),
    .RW0_addr   (addr),
    .RW0_wmask  (wmask),
    .RW0_wdata  (wdata),
    .RW0_rdata  (rdata),
    .RW0_rvalid (rvalid),
    .RW0_ready  (ready)
  );

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] mem_m [DEPTH];
  logic [WIDTH-1:0] q [$];
  logic             m_ready = 1'b0;
  int               m_cnt = 0;
  logic             exp_rv = 1'b0;
  logic [WIDTH-1:0] hold = '0;

  typedef struct {
    logic             wm;
    logic [AW-1:0]    a;
    logic [MW-1:0]    m;
    logic [WIDTH-1:0] d;
    logic             erv;
    logic [WIDTH-1:0] erd;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] apply_mask(input logic [WIDTH-1:0] old,
                                                  input logic [WIDTH-1:0] d,
                                                  input logic [MW-1:0] m);
    logic [WIDTH-1:0] r;
    r = old;
    for (int l = 0; l < MW; l++) begin
      if (m[l]) r[l*GRAN +: GRAN] = d[l*GRAN +: GRAN];
    end
    return r;
  endfunction

  // Apply the current inputs at the next edge, advance the model, then check.
  task automatic cycle();
    logic [WIDTH-1:0] e;
    exp_rv = 1'b0;
    if (rst) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      hold    = '0;
      q.delete();
    end else if (!m_ready) begin
      if (m_cnt == DEPTH - 1) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = IV;
      end else begin
        m_cnt++;
      end
    end else if (en && wmode) begin
      if (addr < DEPTH) mem_m[addr] = apply_mask(mem_m[addr], wdata, wmask);
    end else if (en) begin
      e = (addr < DEPTH) ? mem_m[addr] : '0;
      q.push_back(e);
      hold   = e;
      exp_rv = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("ready", 32'(ready), 32'(m_ready));
    chk("rvalid", 32'(rvalid), 32'(exp_rv));
    if (rvalid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rvalid_no_request: got rvalid=1 want 0 at %0t", $time);
      end else begin
        chk("sb_rdata", 32'(rdata), 32'(q.pop_front()));
      end
    end else if (exp_rv && q.size() != 0) begin
      void'(q.pop_front());
    end
    chk("hold", 32'(rdata), 32'(hold));
  endtask

  initial begin
    int n;

    tbl.push_back('{1'b0, 5'd3,  2'b00, 8'h00, 1'b1, 8'hA5});
    tbl.push_back('{1'b1, 5'd3,  2'b01, 8'h5C, 1'b0, 8'hA5});
    tbl.push_back('{1'b0, 5'd3,  2'b00, 8'h00, 1'b1, 8'hAC});
    tbl.push_back('{1'b1, 5'd3,  2'b10, 8'hF0, 1'b0, 8'hAC});
    tbl.push_back('{1'b0, 5'd3,  2'b00, 8'h00, 1'b1, 8'hFC});
    tbl.push_back('{1'b1, 5'd25, 2'b11, 8'h77, 1'b0, 8'hFC});
    tbl.push_back('{1'b0, 5'd25, 2'b00, 8'h00, 1'b1, 8'h00});
    tbl.push_back('{1'b0, 5'd19, 2'b00, 8'h00, 1'b1, 8'hA5});
    tbl.push_back('{1'b0, 5'd5,  2'b00, 8'h00, 1'b1, 8'hA5});
    tbl.push_back('{1'b1, 5'd5,  2'b11, 8'h33, 1'b0, 8'hA5});
    tbl.push_back('{1'b0, 5'd5,  2'b00, 8'h00, 1'b1, 8'h33});
    tbl.push_back('{1'b1, 5'd0,  2'b00, 8'hFF, 1'b0, 8'h33});
    tbl.push_back('{1'b0, 5'd0,  2'b00, 8'h00, 1'b1, 8'hA5});

    // Reset values, then init latency from the first release.
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      cycle();
      n++;
      if (ready) break;
    end
    chk("init_latency", 32'(n), 32'(DEPTH));

    for (int i = 0; i < tbl.size(); i++) begin
      en    = 1'b1;
      wmode = tbl[i].wm;
      addr  = tbl[i].a;
      wmask = tbl[i].m;
      wdata = tbl[i].d;
      cycle();
      chk($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].erv));
      chk($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tbl[i].erd));
    end
    en = 1'b0;
    cycle();

    // Reset pulsed mid-init, then requests hammered during the second init.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      en    = 1'b1;
      wmode = 1'(i % 2);
      addr  = AW'(i % DEPTH);
      wmask = '1;
      wdata = 8'h3C;
      cycle();
      n++;
      if (ready) break;
    end
    en = 1'b0;
    chk("reinit_latency", 32'(n), 32'(DEPTH));
    for (int i = 0; i < 4; i++) begin
      en    = 1'b1;
      wmode = 1'b0;
      addr  = AW'(2 * i + 1);
      cycle();
      chk($sformatf("reinit_rd%0d", i), 32'(rdata), 32'(IV));
    end
    en = 1'b0;
    cycle();

    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      wmode = 1'($urandom_range(0, 1));
      addr  = AW'($urandom_range(0, 24));
      wmask = MW'($urandom);
      wdata = WIDTH'($urandom);
      cycle();
    end
    en = 1'b0;
    cycle();
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
